// File: rtl/adc_sequencer.sv
// Conversion sequencer for the 8-channel SPI ADC capture block: periodic or
// software triggers, start/done handshake, timeout, and a valid/ready result register.
//
// state   | meaning
// IDLE    | waiting for a trigger, adc_start low
// CONV    | adc_start high, waiting for done or timeout
// RELEASE | adc_start low for RELEASE_CYC cycles so the ADC re-arms
module adc_sequencer #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int RELEASE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [31:0]  period,
  input  logic         sw_trig,
  input  logic         clr_flags,
  output logic         adc_start,
  input  logic         adc_done,
  input  logic [127:0] adc_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         busy,
  output logic         overrun,
  output logic         data_lost,
  output logic         timeout_err,
  output logic [31:0]  sample_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, CONV, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     per_cnt, per_lat, eff_m1;
  logic            tick, trig;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic            capture, abort;

  // Period is sampled at the start of each period so a change lands at the next wrap.
  assign eff_m1 = (per_lat < 32'd2) ? 32'd1 : per_lat - 32'd1;
  assign tick   = enable && (per_cnt == eff_m1);
  assign trig   = tick | sw_trig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      per_lat <= '0;
    end else begin
      if (!enable || tick) per_cnt <= '0;
      else                 per_cnt <= per_cnt + 32'd1;
      if (!enable || per_cnt == 32'd0) per_lat <= period;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = CONV;
          tmr_nxt   = '0;
        end
      end
      CONV: begin
        tmr_nxt = tmr + TW'(1);
        // Done takes priority over a timeout landing on the same cycle.
        if (adc_done) begin
          capture   = 1'b1;
          state_nxt = RELEASE;
          tmr_nxt   = '0;
        end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
          abort     = 1'b1;
          state_nxt = RELEASE;
          tmr_nxt   = '0;
        end
      end
      RELEASE: begin
        tmr_nxt = tmr + TW'(1);
        if (tmr == TW'(RELEASE_CYC - 1)) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  assign adc_start = (state == CONV);
  assign busy      = (state != IDLE);

  // Sticky flags: a set on the same edge as clr_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      overrun      <= 1'b0;
      data_lost    <= 1'b0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      if (capture) begin
        m_data  <= adc_data;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (trig && busy)   overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;

      if (capture && m_valid && !m_ready) data_lost <= 1'b1;
      else if (clr_flags)                 data_lost <= 1'b0;

      if (abort)          timeout_err <= 1'b1;
      else if (clr_flags) timeout_err <= 1'b0;

      if (clr_flags)    sample_count <= capture ? 32'd1 : 32'd0;
      else if (capture) sample_count <= sample_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: behavioural ADC model, event monitors,
// and an arithmetic trigger-schedule reference.
module tb_adc_sequencer;
  localparam int TO = 64;
  localparam int RC = 2;
  localparam logic [127:0] PATTERN = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

  logic         clk = 1'b0, rst = 1'b1;
  logic         enable = 1'b0, sw_trig = 1'b0, clr_flags = 1'b0, m_ready = 1'b1;
  logic [31:0]  period = 32'd0;
  logic         adc_start, adc_done = 1'b0;
  logic [127:0] adc_data = '0;
  logic         m_valid, busy, overrun, data_lost, timeout_err;
  logic [127:0] m_data;
  logic [31:0]  sample_count;

  adc_sequencer #(.TIMEOUT_CYC(TO), .RELEASE_CYC(RC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .sw_trig(sw_trig),
    .clr_flags(clr_flags), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .overrun(overrun), .data_lost(data_lost),
    .timeout_err(timeout_err), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: done rises conv_len cycles after start, clears when start drops.
  int conv_len = 40;
  bit hang = 1'b0, use_pattern = 1'b1;
  int acnt = 0;
  logic [127:0] drv_q[$];
  always @(posedge clk) begin
    #1;
    if (adc_start) begin
      acnt++;
      if (acnt == 1) adc_data = use_pattern ? PATTERN : {$urandom, $urandom, $urandom, $urandom};
    end else acnt = 0;
    adc_done = adc_start && !hang && (acnt > conv_len);
    if (adc_done && acnt == conv_len + 1) drv_q.push_back(adc_data);
  end

  int rise_q[$], fall_q[$], bfall_q[$];
  logic [127:0] acc_q[$];
  bit prev_start = 1'b0, prev_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (adc_start && !prev_start) rise_q.push_back(cyc);
    if (!adc_start && prev_start) fall_q.push_back(cyc);
    if (!busy && prev_busy) bfall_q.push_back(cyc);
    prev_start = adc_start;
    prev_busy  = busy;
  end
  always @(negedge clk) if (m_valid && m_ready) acc_q.push_back(m_data);

  // Reference schedule: ticks every max(P,2) cycles; a tick is honoured only when
  // the previous conversion (L+1 start cycles, RC release cycles) has finished.
  int exp_rise[$];
  function automatic bit predict(input int t0, input int p, input int l, input int tend);
    int eff = (p < 2) ? 2 : p;
    int next_free = t0;
    bit ovr = 1'b0;
    exp_rise.delete();
    for (int t = t0 + eff; t <= tend; t += eff) begin
      if (t >= next_free) begin
        exp_rise.push_back(t);
        next_free = t + l + RC + 2;
      end else ovr = 1'b1;
    end
    return ovr;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sw();
    sw_trig = 1'b1; step(1); sw_trig = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; step(1); clr_flags = 1'b0;
  endtask

  task automatic quiesce();
    int n = 0;
    enable = 1'b0; sw_trig = 1'b0; m_ready = 1'b1; hang = 1'b0;
    step(1);
    while ((busy || m_valid) && n < 300) begin step(1); n++; end
    n_checks++;
    if (busy || m_valid) begin n_fail++; $display("FAIL quiesce: busy=%0b m_valid=%0b after 300 cycles", busy, m_valid); end
    pulse_clr();
    step(1);
    rise_q.delete(); fall_q.delete(); bfall_q.delete(); acc_q.delete(); drv_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++; if (adc_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b want 0", adc_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
    n_checks++; if ({overrun, data_lost, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {overrun, data_lost, timeout_err}); end
    n_checks++; if (sample_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_periodic();
    int t0, td;
    bit ovr;
    quiesce();
    conv_len = 40; use_pattern = 1'b1; period = 32'd100;
    t0 = cyc; enable = 1'b1;
    step(520);
    enable = 1'b0; td = cyc;
    step(60);
    ovr = predict(t0, 100, 40, td);
    n_checks++; if (rise_q.size() != exp_rise.size()) begin n_fail++; $display("FAIL periodic_nrise: got %0d want %0d", rise_q.size(), exp_rise.size()); end
    for (int i = 0; i < rise_q.size() && i < exp_rise.size(); i++) begin
      n_checks++; if (rise_q[i] != exp_rise[i]) begin n_fail++; $display("FAIL periodic_rise%0d: got %0d want %0d", i, rise_q[i] - t0, exp_rise[i] - t0); end
    end
    n_checks++; if (sample_count !== 32'd5) begin n_fail++; $display("FAIL periodic_count: got %0d want 5", sample_count); end
    n_checks++; if (acc_q.size() != 5) begin n_fail++; $display("FAIL periodic_nacc: got %0d want 5", acc_q.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      n_checks++; if (acc_q[i] !== PATTERN) begin n_fail++; $display("FAIL periodic_data%0d: got %h want %h", i, acc_q[i], PATTERN); end
    end
    n_checks++; if ({overrun, data_lost, timeout_err} !== {ovr, 2'b00}) begin n_fail++; $display("FAIL periodic_flags: got %b want %b", {overrun, data_lost, timeout_err}, {ovr, 2'b00}); end
  endtask

  // Scheduled run at period p with conversion length l; checks timing, flags and data.
  task automatic run_sched(input string tag, input int p, input int l, input int len);
    int t0, td;
    bit ovr;
    quiesce();
    conv_len = l; use_pattern = 1'b0; period = p;
    t0 = cyc; enable = 1'b1;
    step(len);
    enable = 1'b0; td = cyc;
    step(l + 10);
    ovr = predict(t0, p, l, td);
    n_checks++; if (rise_q.size() != exp_rise.size()) begin n_fail++; $display("FAIL %s_nrise: got %0d want %0d (p=%0d l=%0d)", tag, rise_q.size(), exp_rise.size(), p, l); end
    for (int i = 0; i < rise_q.size() && i < exp_rise.size(); i++) begin
      n_checks++; if (rise_q[i] != exp_rise[i]) begin n_fail++; $display("FAIL %s_rise%0d: got %0d want %0d", tag, i, rise_q[i] - t0, exp_rise[i] - t0); end
    end
    for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++) begin
      n_checks++; if (fall_q[i] - rise_q[i] != l + 1) begin n_fail++; $display("FAIL %s_highlen%0d: got %0d want %0d", tag, i, fall_q[i] - rise_q[i], l + 1); end
    end
    for (int i = 0; i < bfall_q.size() && i < fall_q.size(); i++) begin
      n_checks++; if (bfall_q[i] - fall_q[i] != RC) begin n_fail++; $display("FAIL %s_release%0d: got %0d want %0d", tag, i, bfall_q[i] - fall_q[i], RC); end
    end
    n_checks++; if (overrun !== ovr) begin n_fail++; $display("FAIL %s_overrun: got %0b want %0b", tag, overrun, ovr); end
    n_checks++; if (sample_count != exp_rise.size()) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, sample_count, exp_rise.size()); end
    n_checks++; if (acc_q.size() != drv_q.size() || acc_q.size() != exp_rise.size()) begin n_fail++; $display("FAIL %s_nacc: got %0d want %0d", tag, acc_q.size(), exp_rise.size()); end
    for (int i = 0; i < acc_q.size() && i < drv_q.size(); i++) begin
      n_checks++; if (acc_q[i] !== drv_q[i]) begin n_fail++; $display("FAIL %s_data%0d: got %h want %h", tag, i, acc_q[i], drv_q[i]); end
    end
  endtask

  task automatic test_overrun();
    run_sched("overrun", 30, 40, 400);
    run_sched("overrun_rnd", $urandom_range(20, 33), $urandom_range(35, 45), 400);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) run_sched($sformatf("rand%0d", k), $urandom_range(20, 90), $urandom_range(5, 45), 300);
  endtask

  task automatic test_timeout();
    int ts;
    quiesce();
    hang = 1'b1; use_pattern = 1'b0;
    ts = cyc; pulse_sw();
    step(80);
    n_checks++; if (rise_q.size() != 1 || fall_q.size() != 1) begin n_fail++; $display("FAIL timeout_edges: got %0d/%0d want 1/1", rise_q.size(), fall_q.size()); end
    else begin
      n_checks++; if (rise_q[0] != ts + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want 1", rise_q[0] - ts); end
      n_checks++; if (fall_q[0] - rise_q[0] != TO) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", fall_q[0] - rise_q[0], TO); end
    end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %0b want 1", timeout_err); end
    n_checks++; if (m_valid !== 1'b0 || acc_q.size() != 0) begin n_fail++; $display("FAIL timeout_valid: got %0b/%0d want 0/0", m_valid, acc_q.size()); end
    n_checks++; if (sample_count !== 32'd0) begin n_fail++; $display("FAIL timeout_count: got %0d want 0", sample_count); end
    // Done arriving on the last allowed cycle must win over the timeout.
    hang = 1'b0; conv_len = TO - 1;
    rise_q.delete(); fall_q.delete();
    pulse_sw();
    step(80);
    n_checks++; if (fall_q.size() != 1 || rise_q.size() != 1 || fall_q[0] - rise_q[0] != TO) begin n_fail++; $display("FAIL edge_done_len: got %0d edges want one of length %0d", fall_q.size(), TO); end
    n_checks++; if (sample_count !== 32'd1) begin n_fail++; $display("FAIL edge_done_count: got %0d want 1", sample_count); end
    n_checks++; if (acc_q.size() != 1 || drv_q.size() != 1 || acc_q[0] !== drv_q[0]) begin n_fail++; $display("FAIL edge_done_data: got %0d results want 1 matching", acc_q.size()); end
    pulse_clr();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %0b want 0", timeout_err); end
  endtask

  task automatic test_sw_trig();
    int ts, t0;
    quiesce();
    conv_len = $urandom_range(5, 20); use_pattern = 1'b0; period = 32'd7;
    ts = cyc; pulse_sw();
    step(40);
    n_checks++; if (rise_q.size() != 1 || rise_q[0] != ts + 1) begin n_fail++; $display("FAIL sw_single: got %0d rises want 1 at +1", rise_q.size()); end
    n_checks++; if (sample_count !== 32'd1 || acc_q.size() != 1 || acc_q[0] !== drv_q[0]) begin n_fail++; $display("FAIL sw_result: got count %0d acc %0d want 1/1", sample_count, acc_q.size()); end
    // sw_trig on the same cycle as a tick is one trigger.
    quiesce();
    period = 32'd50;
    t0 = cyc; enable = 1'b1;
    step(49);
    pulse_sw();
    step(9);
    enable = 1'b0;
    step(40);
    n_checks++; if (rise_q.size() != 1 || rise_q[0] != t0 + 50) begin n_fail++; $display("FAIL coincide_rise: got %0d rises want 1 at +50", rise_q.size()); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coincide_overrun: got %0b want 0", overrun); end
    // period=1 behaves as period=2.
    quiesce();
    period = 32'd1; conv_len = 5;
    t0 = cyc; enable = 1'b1;
    step(2);
    enable = 1'b0;
    step(20);
    n_checks++; if (rise_q.size() != 1 || rise_q[0] != t0 + 2) begin n_fail++; $display("FAIL period1: got %0d rises want 1 at +2", rise_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ts, bad = 0;
    logic [127:0] da;
    quiesce();
    m_ready = 1'b0; conv_len = 10; use_pattern = 1'b0;
    pulse_sw(); step(20);
    n_checks++; if (m_valid !== 1'b1 || m_data !== drv_q[0]) begin n_fail++; $display("FAIL bp_first: got v=%0b %h want 1 %h", m_valid, m_data, drv_q[0]); end
    n_checks++; if (data_lost !== 1'b0) begin n_fail++; $display("FAIL bp_nolost: got %0b want 0", data_lost); end
    pulse_sw();
    for (int i = 0; i < 20; i++) begin step(1); if (m_valid !== 1'b1) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: m_valid low %0d cycles want 0", bad); end
    n_checks++; if (drv_q.size() != 2 || m_data !== drv_q[1]) begin n_fail++; $display("FAIL bp_overwrite: got %h want second result", m_data); end
    n_checks++; if (data_lost !== 1'b1) begin n_fail++; $display("FAIL bp_lost: got %0b want 1", data_lost); end
    m_ready = 1'b1; step(1); m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || acc_q.size() != 1) begin n_fail++; $display("FAIL bp_accept: got v=%0b acc=%0d want 0/1", m_valid, acc_q.size()); end
    pulse_clr();
    n_checks++; if (data_lost !== 1'b0 || sample_count !== 32'd0) begin n_fail++; $display("FAIL bp_clr: got lost=%0b cnt=%0d want 0/0", data_lost, sample_count); end
    // Capture, accept and clear all on the same edge.
    pulse_sw(); step(20);
    da = m_data;
    ts = cyc; pulse_sw();
    step(conv_len);
    m_ready = 1'b1; clr_flags = 1'b1;
    step(1);
    m_ready = 1'b0; clr_flags = 1'b0;
    n_checks++; if (m_valid !== 1'b1 || m_data !== drv_q[drv_q.size()-1]) begin n_fail++; $display("FAIL same_edge_data: got v=%0b %h want 1 %h", m_valid, m_data, drv_q[drv_q.size()-1]); end
    n_checks++; if (data_lost !== 1'b0) begin n_fail++; $display("FAIL same_edge_lost: got %0b want 0", data_lost); end
    n_checks++; if (sample_count !== 32'd1) begin n_fail++; $display("FAIL clr_vs_capture: got %0d want 1", sample_count); end
    n_checks++; if (acc_q.size() != 2 || acc_q[1] !== da) begin n_fail++; $display("FAIL same_edge_old: got %0d accepts want old result accepted", acc_q.size()); end
  endtask

  task automatic test_rst_mid();
    quiesce();
    m_ready = 1'b0; conv_len = 10; use_pattern = 1'b0;
    pulse_sw(); step(20);
    pulse_sw(); step(5);
    @(negedge clk); #2; rst = 1'b1; #1;
    n_checks++; if (adc_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start: got start=%0b busy=%0b want 0/0", adc_start, busy); end
    n_checks++; if (m_valid !== 1'b0 || sample_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_valid: got v=%0b cnt=%0d want 0/0", m_valid, sample_count); end
    @(posedge clk); #1; rst = 1'b0; m_ready = 1'b1;
    step(2);
    rise_q.delete(); fall_q.delete(); acc_q.delete(); drv_q.delete();
    pulse_sw(); step(30);
    n_checks++; if (sample_count !== 32'd1 || acc_q.size() != 1 || drv_q.size() != 1 || acc_q[0] !== drv_q[0]) begin n_fail++; $display("FAIL rst_resume: got cnt=%0d acc=%0d want 1/1", sample_count, acc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_timeout();
    test_sw_trig();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Sequences the 8-channel SPI ADC capture block: issues periodic or software-triggered conversions, drives its level-sensitive start, waits for done, and latches the 128-bit result.
- Presents each result downstream on a valid/ready output register.
- Detects missed triggers, hung conversions and unconsumed results.
- Sits between the control-register bank and the ADC capture block.

Parameters:
- TIMEOUT_CYC, 4096: max clk cycles in CONV before abort; must exceed 32*clk_div+4 for the configured divider.
- RELEASE_CYC, 2: cycles adc_start is held low after each conversion, so the ADC clears done and re-arms; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  1 = periodic mode running; 0 = period counter held at 0
- period  in  32  trigger period in clk cycles; 0 or 1 treated as 2
- sw_trig  in  1  single-cycle software trigger, honoured regardless of enable
- clr_flags  in  1  single-cycle clear of sticky flags and counters
- adc_start  out  1  start level to ADC block
- adc_done  in  1  done level from ADC block
- adc_data  in  128  8x16-bit result from ADC block; ch1 in [15:0] ... ch8 in [127:112]
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  128  latched result
- busy  out  1  high in CONV or RELEASE
- overrun  out  1  sticky: trigger arrived while busy
- data_lost  out  1  sticky: result overwritten before accepted
- timeout_err  out  1  sticky: conversion aborted by timeout
- sample_count  out  32  completed conversions, wraps 2^32-1 -> 0

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: adc_start, m_valid, m_data, busy, flags, sample_count. Period and timeout counters 0.
- Period counter:
  - While enable=1, increments each cycle.
  - On reaching eff_period-1, wraps to 0 and raises tick for 1 cycle. eff_period = max(period,2).
  - enable=0 clears the counter; a period change takes effect at the next wrap.
- trig = tick | sw_trig. Simultaneous tick and sw_trig count as one trigger.
- FSM:
  - IDLE: adc_start=0. On trig -> CONV, with adc_start=1 from the next cycle and the timeout counter cleared.
  - CONV: adc_start=1; timeout counter increments.
    - On adc_done=1, capture adc_data into m_data the same edge, set m_valid, increment sample_count -> RELEASE.
    - If the timeout counter reaches TIMEOUT_CYC-1 with done still 0, set timeout_err, no capture -> RELEASE.
    - Done wins if both occur on the same cycle.
  - RELEASE: adc_start=0 for exactly RELEASE_CYC cycles -> IDLE. A trigger arriving here is a miss.
- Latency: trig at cycle T -> adc_start high at T+1; done sampled at cycle D -> m_valid high at D+1.
- Any trig while busy or on the transition edge out of IDLE is dropped and sets overrun. No queuing.
- Output handshake:
  - m_valid clears on m_valid & m_ready.
  - If a capture coincides with m_valid=1 & m_ready=0, the new data overwrites m_data, m_valid stays 1, and data_lost is set.
  - Capture and accept on the same edge: new data is loaded, m_valid stays 1, no loss.
- clr_flags clears overrun, data_lost, timeout_err and sample_count. Flag set and clear on the same edge: set wins, so sample_count = 1 if a capture coincides.
- enable 1->0 mid-conversion: the current conversion completes normally; only new ticks stop.
- rst mid-conversion: adc_start drops immediately. The ADC recovers by itself because start=0 with cs high re-idles it.

Test Plan:
- period=100, enable=1, ADC model done 40 cycles after start -> adc_start rises 1 cycle after each tick, m_valid pulses once per 100 cycles, m_data matches model pattern 128'h0008_0007_..._0001, sample_count=5 after 500 cycles, no flags set.
- m_ready=0 for two conversions -> first result held, then overwritten by the second; data_lost=1 and m_valid=1 throughout; m_ready=1 then clears m_valid; clr_flags clears data_lost.
- period=30, conversion length 40 -> every tick during CONV/RELEASE sets overrun, and conversions occur at most one per (40+2+wait) cycles; adc_start low for exactly 2 cycles between conversions.
- Model never asserts done, TIMEOUT_CYC=64 -> adc_start high exactly 64 cycles then low, timeout_err=1, m_valid stays 0, sample_count unchanged; the next trigger starts a fresh conversion.
- enable=0, sw_trig pulse -> single conversion; sw_trig and tick on the same cycle with enable=1 -> one conversion, overrun=0.
- rst asserted mid-CONV between clock edges -> adc_start, busy and m_valid go 0 immediately without a clock edge; after rst release with a trigger, normal operation resumes.
